// File: rtl/ddr3_ctrl_pkg.sv
// rtl/ddr3_ctrl_pkg.sv - shared types and defaults for the DDR3 access sequencer
package ddr3_ctrl_pkg;

   localparam int BURST_LEN_DEF  = 16;
   localparam int XFER_WORDS_DEF = 640;
   localparam int BURSTCNT_W     = 7;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR_CMD  = 2'd1,
      S_RD_CMD  = 2'd2,
      S_RD_DATA = 2'd3
   } state_t;

endpackage

// File: rtl/ddr3_access_sequencer_if.sv
// rtl/ddr3_access_sequencer_if.sv - Avalon-MM master bus bundle for the sequencer
interface ddr3_access_sequencer_if
   import ddr3_ctrl_pkg::*;
#(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 32
) ();

   logic [ADDR_W-1:0]     avm_address;
   logic                  avm_read;
   logic                  avm_write;
   logic [BURSTCNT_W-1:0] avm_burstcount;
   logic [DATA_W-1:0]     avm_writedata;
   logic                  avm_waitrequest;
   logic [DATA_W-1:0]     avm_readdata;
   logic                  avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_write, avm_burstcount, avm_writedata,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_burstcount, avm_writedata,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with lock and update strobe
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       lock_i,
   input  logic       update_i,
   input  logic       done_idx_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   logic prio_q;
   logic prio_d;

   // The requester that just completed drops to lower priority
   always_comb begin
      prio_d = prio_q;
      if (update_i) begin
         prio_d = ~done_idx_i;
      end
   end

   // Priority pointer, favouring requester 0 out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   // Grant the favoured requester, else the other; no new grant while locked
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = prio_q;
      if (!lock_i) begin
         if (req_i[prio_q]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = prio_q;
         end else if (req_i[~prio_q]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = ~prio_q;
         end
      end
   end

endmodule

// File: rtl/ddr3_access_sequencer.sv
// rtl/ddr3_access_sequencer.sv - sequences display-buffer burst reads and CSR test writes onto DDR3
module ddr3_access_sequencer
   import ddr3_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = BURST_LEN_DEF,
   parameter int XFER_WORDS = XFER_WORDS_DEF,
   parameter int SPACE_W    = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                buf0_ready,
   input  logic                buf1_ready,
   input  logic [ADDR_W-1:0]   buf0_offset,
   input  logic [ADDR_W-1:0]   buf1_offset,
   input  logic                test_wr,
   input  logic [31:0]         test_addr,
   input  logic [DATA_W-1:0]   test_wr_data,
   output logic                clear_buffer0,
   output logic                clear_buffer1,
   output logic                wr_finish,
   ddr3_access_sequencer_if.master avm,
   input  logic [SPACE_W-1:0]  fifo_space,
   output logic                pix_wr,
   output logic [DATA_W-1:0]   pix_data,
   output logic                pix_buf,
   output logic                busy
);

   localparam int BC_W = $clog2(BURST_LEN) + 1;
   localparam int WC_W = $clog2(XFER_WORDS) + 1;
   localparam logic [BC_W-1:0]    BEAT_LAST   = BC_W'(BURST_LEN - 1);
   localparam logic [WC_W-1:0]    WORD_LAST   = WC_W'(XFER_WORDS - 1);
   localparam logic [SPACE_W:0]   BURST_SPACE = (SPACE_W + 1)'(BURST_LEN);

   state_t            state_q, state_d;
   logic              wr_pend_q, wr_pend_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              lock_q, lock_d;
   logic              lk_buf_q, lk_buf_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic              wr_finish_q, wr_finish_d;
   logic              clear0_q, clear0_d;
   logic              clear1_q, clear1_d;
   logic              pix_wr_q, pix_wr_d;
   logic [DATA_W-1:0] pix_data_q, pix_data_d;
   logic              pix_buf_q, pix_buf_d;

   logic              space_ok;
   logic              gnt_valid;
   logic              gnt_idx;
   logic              arb_update;
   logic [ADDR_W-1:0] rd_base;
   logic              unused_test_addr;

   assign space_ok         = {1'b0, fifo_space} >= BURST_SPACE;
   assign rd_base          = lk_buf_q ? buf1_offset : buf0_offset;
   assign unused_test_addr = ^test_addr[31:ADDR_W];

   rr_arbiter2 u_arb (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_i       ({buf1_ready, buf0_ready}),
      .lock_i      (lock_q),
      .update_i    (arb_update),
      .done_idx_i  (lk_buf_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // Next-state: request capture, IDLE arbitration, command handshakes and beat counting
   always_comb begin
      state_d     = state_q;
      wr_pend_d   = wr_pend_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      lock_d      = lock_q;
      lk_buf_d    = lk_buf_q;
      word_cnt_d  = word_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      wr_finish_d = 1'b0;
      clear0_d    = 1'b0;
      clear1_d    = 1'b0;
      pix_wr_d    = 1'b0;
      pix_data_d  = pix_data_q;
      pix_buf_d   = pix_buf_q;
      arb_update  = 1'b0;

      if (test_wr && !wr_pend_q) begin
         wr_pend_d = 1'b1;
         wr_addr_d = test_addr[ADDR_W-1:0];
         wr_data_d = test_wr_data;
      end

      case (state_q)
         S_IDLE: begin
            if (wr_pend_q) begin
               state_d = S_WR_CMD;
            end else if (lock_q) begin
               if (space_ok) state_d = S_RD_CMD;
            end else if (gnt_valid) begin
               lock_d     = 1'b1;
               lk_buf_d   = gnt_idx;
               word_cnt_d = '0;
               if (space_ok) state_d = S_RD_CMD;
            end
         end
         S_WR_CMD: begin
            if (!avm.avm_waitrequest) begin
               wr_finish_d = 1'b1;
               wr_pend_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         S_RD_CMD: begin
            if (!avm.avm_waitrequest) begin
               beat_cnt_d = '0;
               state_d    = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (avm.avm_readdatavalid) begin
               pix_wr_d   = 1'b1;
               pix_data_d = avm.avm_readdata;
               pix_buf_d  = lk_buf_q;
               word_cnt_d = word_cnt_q + 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == BEAT_LAST) begin
                  state_d = S_IDLE;
                  if (word_cnt_q == WORD_LAST) begin
                     lock_d     = 1'b0;
                     arb_update = 1'b1;
                     clear0_d   = ~lk_buf_q;
                     clear1_d   = lk_buf_q;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         wr_pend_q   <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         lock_q      <= 1'b0;
         lk_buf_q    <= 1'b0;
         word_cnt_q  <= '0;
         beat_cnt_q  <= '0;
         wr_finish_q <= 1'b0;
         clear0_q    <= 1'b0;
         clear1_q    <= 1'b0;
         pix_wr_q    <= 1'b0;
         pix_data_q  <= '0;
         pix_buf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_pend_q   <= wr_pend_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         lock_q      <= lock_d;
         lk_buf_q    <= lk_buf_d;
         word_cnt_q  <= word_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         wr_finish_q <= wr_finish_d;
         clear0_q    <= clear0_d;
         clear1_q    <= clear1_d;
         pix_wr_q    <= pix_wr_d;
         pix_data_q  <= pix_data_d;
         pix_buf_q   <= pix_buf_d;
      end
   end

   // Bus outputs decode straight from registered state so they hold steady under waitrequest
   always_comb begin
      avm.avm_read       = (state_q == S_RD_CMD);
      avm.avm_write      = (state_q == S_WR_CMD);
      avm.avm_address    = '0;
      avm.avm_burstcount = '0;
      avm.avm_writedata  = '0;
      if (state_q == S_RD_CMD) begin
         avm.avm_address    = rd_base + ADDR_W'(word_cnt_q);
         avm.avm_burstcount = BURSTCNT_W'(BURST_LEN);
      end else if (state_q == S_WR_CMD) begin
         avm.avm_address    = wr_addr_q;
         avm.avm_burstcount = BURSTCNT_W'(1);
         avm.avm_writedata  = wr_data_q;
      end
   end

   assign clear_buffer0 = clear0_q;
   assign clear_buffer1 = clear1_q;
   assign wr_finish     = wr_finish_q;
   assign pix_wr        = pix_wr_q;
   assign pix_data      = pix_data_q;
   assign pix_buf       = pix_buf_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/ddr3_access_sequencer.md
Name: ddr3_access_sequencer

Overview:
Single-port Avalon-MM master that sequences all DDR3 traffic for the display path in the DDR3 clock domain. Shares the memory between two display-buffer fetch requesters and one CSR test-write requester. Buffer fetches stream burst read data into the pixel FIFO and, on completion, pulse the clear_buffer0/1 strobes consumed by the CSR block. The test write returns wr_finish.

Parameters:
ADDR_W, 26, DDR3 word address width
DATA_W, 32, Avalon data width
BURST_LEN, 16, words per read burst (power of 2, ≤ 64)
XFER_WORDS, 640, words per buffer fetch (integer multiple of BURST_LEN)
SPACE_W, 10, width of fifo_space

Ports:
clk  in  1  clock; reset reset_n, asynchronous, active-low; clock clk
reset_n  in  1  async active-low reset
buf0_ready  in  1  level; buffer0 is armed (inverse of ddr3_rd_buffer0_empty)
buf1_ready  in  1  level; buffer1 is armed
buf0_offset  in  ADDR_W  buffer0 base word address; quasi-static
buf1_offset  in  ADDR_W  buffer1 base word address; quasi-static
test_wr  in  1  1-cycle request pulse, already synchronised
test_addr  in  32  test write address; [ADDR_W-1:0] used
test_wr_data  in  DATA_W  test write data
clear_buffer0  out  1  1-cycle pulse: buffer0 fetch complete
clear_buffer1  out  1  1-cycle pulse: buffer1 fetch complete
wr_finish  out  1  1-cycle pulse: test write accepted
avm_address  out  ADDR_W  word address
avm_read  out  1  read command
avm_write  out  1  write command
avm_burstcount  out  7  burst length
avm_writedata  out  DATA_W  write data
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  read beat valid
fifo_space  in  SPACE_W  free words in pixel FIFO
pix_wr  out  1  pixel FIFO write strobe
pix_data  out  DATA_W  pixel FIFO write data
pix_buf  out  1  source buffer of current beat
busy  out  1  state ≠ IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; write-pending flag, word counter, lock and round-robin pointer cleared (pointer favours buf0). Reset mid-burst abandons the transfer. No clear pulse is issued. Outstanding readdatavalid beats after reset are dropped.
- test_wr sets wr_pend; test_addr and test_wr_data are captured on the same edge. A test_wr pulse while wr_pend is set is ignored.
- States: IDLE, WR_CMD, RD_CMD, RD_DATA.
- IDLE decision, priority order:
  - wr_pend → WR_CMD.
  - Otherwise, a locked (in-progress) buffer with fifo_space ≥ BURST_LEN → RD_CMD.
  - Otherwise, no lock: pick a ready buffer by round-robin; the last-completed buffer has lower priority. Lock it and load word_cnt = 0. Enter RD_CMD only if fifo_space ≥ BURST_LEN; else stay in IDLE with the lock held.
- WR_CMD: avm_write = 1, burstcount = 1, address = captured addr, writedata = captured data. Hold all until avm_waitrequest = 0. On that edge: wr_finish pulses next cycle, wr_pend clears, → IDLE.
- RD_CMD: avm_read = 1, burstcount = BURST_LEN, address = offset(locked) + word_cnt. Hold stable until avm_waitrequest = 0, then → RD_DATA. Command deasserts the cycle after acceptance.
- RD_DATA:
  - Each avm_readdatavalid → pix_wr = 1, pix_data = readdata, pix_buf = locked buffer, registered with 1-cycle latency; word_cnt++.
  - After BURST_LEN beats: if word_cnt == XFER_WORDS, pulse clear_bufferN, release the lock, update the round-robin pointer, → IDLE. Otherwise → IDLE with the lock held.
  - A pending write therefore preempts only at burst boundaries.
- readdatavalid outside RD_DATA is ignored.
- A buffer whose ready drops mid-fetch is still completed; ready is sampled only at lock time.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Reads and writes are never issued concurrently; at most one burst is outstanding.

Decomposition:
- Package ddr3_ctrl_pkg: state enum, BURST_LEN/XFER_WORDS defaults, burstcount width constant.
- Sub-module rr_arbiter2: 2-requester round-robin with a lock input and grant-update strobe.

Test Plan:
1. test_wr with addr = 0x100, data = 0xDEADBEEF, waitrequest high for 3 cycles → avm_write held 4 cycles with stable addr/data; wr_finish pulses exactly once.
2. buf0_ready = 1, offset = 0x1000, XFER_WORDS = 32, BURST_LEN = 16, fifo_space = 512 → two read commands at 0x1000 and 0x1010; 32 pix_wr with pix_buf = 0; one clear_buffer0 pulse.
3. buf0 and buf1 ready together, repeatedly re-armed → fetches alternate 0, 1, 0, 1; a buffer is never granted twice in a row while the other is ready.
4. test_wr arrives during the first burst of a buf1 fetch → write is issued after that burst's 16th beat, before the second burst; the buf1 fetch resumes at offset + 16.
5. fifo_space = 15 → no avm_read is issued; raising fifo_space to 16 starts the burst within 2 cycles.
6. reset_n asserted after beat 5 of a burst → all outputs 0, no clear pulse; after release, re-arming buf0 restarts the fetch at offset + 0.
